// File: rtl/uz_error_collector_pkg.sv
// Shared types and helpers for the fault collector: FSM states, event record
// layout and the lowest-set-bit priority encoder used to pick the first fault.
package uz_error_collector_pkg;

    localparam int NUM_ERR_MAX = 32;
    localparam int ERR_ID_W    = 5;
    localparam int TS_W_MAX    = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRIPPED  = 2'd1,
        CLEARING = 2'd2
    } state_t;

    // Sized for the widest configuration; narrower instances use the low bits.
    typedef struct packed {
        logic [NUM_ERR_MAX-1:0] bits;
        logic [TS_W_MAX-1:0]    ts;
    } ev_rec_t;

    function automatic logic [ERR_ID_W-1:0] lowest_index(input logic [NUM_ERR_MAX-1:0] v);
        lowest_index = '0;
        for (int i = NUM_ERR_MAX - 1; i >= 0; i--) begin
            if (v[i]) lowest_index = ERR_ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/uz_error_filter.sv
// One fault source: 2-FF synchronizer followed by a saturating run-length
// counter; filt is registered so acceptance lands 3+filter_len edges after capture.
module uz_error_filter #(
    parameter int FILTER_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                err_raw,
    input  logic [FILTER_W-1:0] filter_len,
    output logic                filt
);

    logic                sync1;
    logic                sync2;
    logic [FILTER_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            filt  <= 1'b0;
        end else begin
            sync1 <= err_raw;
            sync2 <= sync1;
            if (!sync2) begin
                cnt <= '0;
            end else if (cnt < filter_len) begin
                cnt <= cnt + 1'b1;
            end
            // Accept only once the synced level has held for filter_len+1 cycles.
            filt <= sync2 && (cnt >= filter_len);
        end
    end

endmodule

// File: rtl/uz_error_collector.sv
// Fault collector: filters, masks and latches fault lines, records the first
// fault, emits per-event records (valid/ready) and drives the trip line.
module uz_error_collector
    import uz_error_collector_pkg::*;
#(
    parameter int NUM_ERR  = 8,
    parameter int FILTER_W = 8,
    parameter int TS_W     = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [NUM_ERR-1:0]  err_in,
    input  logic [NUM_ERR-1:0]  err_mask,
    input  logic [FILTER_W-1:0] filter_len,
    input  logic                clear_req,
    output logic                clear_ack,
    output logic [NUM_ERR-1:0]  err_flags,
    output logic                trip,
    output logic                first_valid,
    output logic [ERR_ID_W-1:0] first_id,
    output logic [TS_W-1:0]     first_ts,
    // ev_valid holds with ev_bits/ev_ts stable until a cycle with ev_valid && ev_ready.
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [NUM_ERR-1:0]  ev_bits,
    output logic [TS_W-1:0]     ev_ts,
    output logic                ev_overflow,
    output logic [1:0]          dbg_state
);

    state_t             state;
    logic [TS_W-1:0]    ts;
    logic [NUM_ERR-1:0] filt;
    logic [NUM_ERR-1:0] new_bits;
    logic [NUM_ERR-1:0] keep;
    logic [NUM_ERR-1:0] flags_next;
    logic               clear_done;

    for (genvar gi = 0; gi < NUM_ERR; gi++) begin : g_filt
        uz_error_filter #(.FILTER_W(FILTER_W)) u_filt (
            .clk        (ACLK),
            .rst        (ARESET),
            .err_raw    (err_in[gi]),
            .filter_len (filter_len),
            .filt       (filt[gi])
        );
    end

    always_comb begin
        new_bits   = filt & err_mask & ~err_flags;
        // While clearing, a flag survives only if its source is still enabled and active.
        keep       = (state == CLEARING) ? (err_flags & filt & err_mask) : err_flags;
        flags_next = keep | new_bits;
        clear_done = (state == CLEARING) && (flags_next == '0);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= IDLE;
            ts          <= '0;
            err_flags   <= '0;
            trip        <= 1'b0;
            clear_ack   <= 1'b0;
            first_valid <= 1'b0;
            first_id    <= '0;
            first_ts    <= '0;
            ev_valid    <= 1'b0;
            ev_bits     <= '0;
            ev_ts       <= '0;
            ev_overflow <= 1'b0;
        end else begin
            ts        <= ts + 1'b1;
            err_flags <= flags_next;
            trip      <= |flags_next;
            clear_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (|new_bits) begin
                        first_valid <= 1'b1;
                        first_id    <= lowest_index(NUM_ERR_MAX'(new_bits));
                        first_ts    <= ts;
                        state       <= TRIPPED;
                    end
                    if (clear_req) clear_ack <= 1'b1;
                end
                TRIPPED: begin
                    if (clear_req) state <= CLEARING;
                end
                CLEARING: begin
                    if (clear_done) begin
                        clear_ack   <= 1'b1;
                        first_valid <= 1'b0;
                        first_id    <= '0;
                        first_ts    <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Single-entry event register: replace on accept, drop and flag when blocked.
            if (|new_bits) begin
                if (!ev_valid || ev_ready) begin
                    ev_valid <= 1'b1;
                    ev_bits  <= new_bits;
                    ev_ts    <= ts;
                end else begin
                    ev_overflow <= 1'b1;
                end
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end

            if (clear_done) ev_overflow <= 1'b0;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_uz_error_collector.sv
// Bench for uz_error_collector: directed scenarios with literal expectations plus
// randomized rounds checked every cycle against a window-based behavioural model.
module tb_uz_error_collector;
    import uz_error_collector_pkg::*;

    localparam int NUM_ERR  = 8;
    localparam int FILTER_W = 8;
    localparam int TS_W     = 32;
    localparam int HIST     = 270;

    logic                ACLK;
    logic                ARESET;
    logic [NUM_ERR-1:0]  err_in;
    logic [NUM_ERR-1:0]  err_mask;
    logic [FILTER_W-1:0] filter_len;
    logic                clear_req;
    logic                clear_ack;
    logic [NUM_ERR-1:0]  err_flags;
    logic                trip;
    logic                first_valid;
    logic [ERR_ID_W-1:0] first_id;
    logic [TS_W-1:0]     first_ts;
    logic                ev_valid;
    logic                ev_ready;
    logic [NUM_ERR-1:0]  ev_bits;
    logic [TS_W-1:0]     ev_ts;
    logic                ev_overflow;
    logic [1:0]          dbg_state;

    uz_error_collector #(.NUM_ERR(NUM_ERR), .FILTER_W(FILTER_W), .TS_W(TS_W)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .err_in      (err_in),
        .err_mask    (err_mask),
        .filter_len  (filter_len),
        .clear_req   (clear_req),
        .clear_ack   (clear_ack),
        .err_flags   (err_flags),
        .trip        (trip),
        .first_valid (first_valid),
        .first_id    (first_id),
        .first_ts    (first_ts),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_bits     (ev_bits),
        .ev_ts       (ev_ts),
        .ev_overflow (ev_overflow),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A source is accepted at edge e when it was sampled high on every edge
    // e-3-filter_len .. e-3 (2-FF sync + filter + latch register).
    logic [NUM_ERR-1:0] smp_q[$];
    logic [39:0]        exp_q[$];
    logic [NUM_ERR-1:0] m_flags;
    state_t             m_phase;
    logic               m_first_valid;
    logic [4:0]         m_first_id;
    logic [31:0]        m_first_ts;
    ev_rec_t            m_ev;
    logic               m_ev_valid;
    logic               m_ovf;
    logic               m_ack;
    logic [31:0]        m_ts;
    int                 e_cnt = -1;
    bit                 model_live = 0;

    logic [NUM_ERR-1:0] acc, new_b;
    logic               done, found;

    always @(posedge ACLK) begin
        if (ARESET) begin
            m_flags = '0; m_phase = IDLE; m_first_valid = 0; m_first_id = '0;
            m_first_ts = '0; m_ev = '0; m_ev_valid = 0; m_ovf = 0; m_ack = 0; m_ts = '0;
            smp_q.delete();
            for (int k = 0; k < HIST; k++) smp_q.push_back('0);
            exp_q.delete();
            e_cnt = -1;
            model_live = 1;
        end else if (model_live) begin
            acc = '1;
            for (int j = 2; j <= 2 + int'(filter_len); j++) acc &= smp_q[j];
            new_b = acc & err_mask & ~m_flags;
            done  = 0;
            m_ack = 0;
            case (m_phase)
                IDLE: begin
                    if (new_b != 0) begin
                        found = 0;
                        for (int i = 0; i < NUM_ERR; i++)
                            if (new_b[i] && !found) begin m_first_id = 5'(i); found = 1; end
                        m_first_valid = 1;
                        m_first_ts    = m_ts;
                        m_phase       = TRIPPED;
                    end
                    if (clear_req) m_ack = 1;
                    m_flags |= new_b;
                end
                TRIPPED: begin
                    m_flags |= new_b;
                    if (clear_req) m_phase = CLEARING;
                end
                default: begin
                    m_flags = (m_flags & acc & err_mask) | new_b;
                    done = (m_flags == 0);
                end
            endcase
            if (new_b != 0) begin
                if (!m_ev_valid || ev_ready) begin
                    m_ev_valid = 1;
                    m_ev.bits  = 32'(new_b);
                    m_ev.ts    = 64'(m_ts);
                    exp_q.push_back({new_b, m_ts});
                end else begin
                    m_ovf = 1;
                end
            end else if (m_ev_valid && ev_ready) begin
                m_ev_valid = 0;
            end
            if (done) begin
                m_ack = 1; m_first_valid = 0; m_first_id = '0; m_first_ts = '0;
                m_ovf = 0; m_phase = IDLE;
            end
            m_ts++;
            smp_q.push_front(err_in);
            void'(smp_q.pop_back());
            e_cnt++;
        end
    end

    // ---------------- per-cycle compare + event scoreboard ----------------
    logic [39:0] exp_rec;
    always @(negedge ACLK) begin
        if (model_live) begin
            check("flags",       64'(err_flags),   64'(m_flags));
            check("trip",        64'(trip),        64'(|m_flags));
            check("first_valid", 64'(first_valid), 64'(m_first_valid));
            check("first_id",    64'(first_id),    64'(m_first_id));
            check("first_ts",    64'(first_ts),    64'(m_first_ts));
            check("ev_valid",    64'(ev_valid),    64'(m_ev_valid));
            check("ev_overflow", 64'(ev_overflow), 64'(m_ovf));
            check("clear_ack",   64'(clear_ack),   64'(m_ack));
            check("state",       64'(dbg_state),   64'(m_phase));
            if (m_ev_valid) begin
                check("ev_bits", 64'(ev_bits), 64'(m_ev.bits[NUM_ERR-1:0]));
                check("ev_ts",   64'(ev_ts),   64'(m_ev.ts[TS_W-1:0]));
            end
            if (!ARESET && ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    check("ev_accept_unexpected", 64'(ev_bits), 64'h0);
                end else begin
                    exp_rec = exp_q.pop_front();
                    check("sb_bits", 64'(ev_bits), 64'(exp_rec[39:32]));
                    check("sb_ts",   64'(ev_ts),   64'(exp_rec[31:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int len);
        ARESET = 1; err_in = '0; clear_req = 0; ev_ready = 0;
        err_mask = '1; filter_len = FILTER_W'(len);
        repeat (2) begin @(posedge ACLK); #1; end
        ARESET = 0;
    endtask

    // Advance to just after non-reset edge n (edge 0 = first edge after release).
    task automatic goto_edge(input int n);
        int guard = 0;
        while (e_cnt < n && guard < 2000) begin
            @(posedge ACLK); #1;
            guard++;
        end
        if (e_cnt < n) check("goto_edge_timeout", 64'(e_cnt), 64'(n));
    endtask

    task automatic at_neg();
        @(negedge ACLK);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ARESET = 1; err_in = '0; err_mask = '1; filter_len = 8'd3;
        clear_req = 0; ev_ready = 0;

        // T1: basic latency and reset state
        do_reset(3);
        at_neg();
        check("rst_flags", 64'(err_flags), 64'h0);
        check("rst_trip",  64'(trip),      64'h0);
        check("rst_evv",   64'(ev_valid),  64'h0);
        goto_edge(9);  err_in = 8'h04;
        goto_edge(15); at_neg();
        check("t1_flags_e15", 64'(err_flags), 64'h00);
        goto_edge(16); at_neg();
        check("t1_flags", 64'(err_flags), 64'h04);
        check("t1_trip",  64'(trip),      64'h1);
        check("t1_evbits", 64'(ev_bits),  64'h04);
        check("t1_evts",  64'(ev_ts),     64'd16);
        check("t1_fid",   64'(first_id),  64'd2);
        check("t1_fval",  64'(first_valid), 64'h1);
        check("t1_fts",   64'(first_ts),  64'd16);

        // T2: short pulse rejected, exact-length pulse accepted
        do_reset(3);
        goto_edge(4);  err_in = 8'h20;
        goto_edge(7);  err_in = 8'h00;
        goto_edge(20); at_neg();
        check("t2_short_flags", 64'(err_flags), 64'h0);
        check("t2_short_evv",   64'(ev_valid),  64'h0);
        check("t2_short_trip",  64'(trip),      64'h0);
        goto_edge(24); err_in = 8'h20;
        goto_edge(28); err_in = 8'h00;
        goto_edge(35); at_neg();
        check("t2_exact_flags", 64'(err_flags), 64'h20);

        // T3: simultaneous sources
        do_reset(3);
        goto_edge(4);  err_in = 8'h42;
        goto_edge(12); at_neg();
        check("t3_fid",    64'(first_id),  64'd1);
        check("t3_evbits", 64'(ev_bits),   64'h42);
        check("t3_flags",  64'(err_flags), 64'h42);

        // T4: blocked event register overflows
        do_reset(3);
        goto_edge(2);  err_in = 8'h01;
        goto_edge(15); err_in = 8'h09;
        goto_edge(30); at_neg();
        check("t4_evbits", 64'(ev_bits),     64'h01);
        check("t4_evts",   64'(ev_ts),       64'd9);
        check("t4_ovf",    64'(ev_overflow), 64'h1);
        check("t4_flags",  64'(err_flags),   64'h09);
        @(posedge ACLK); #1; ev_ready = 1;
        @(posedge ACLK); #1; ev_ready = 0;
        at_neg();
        check("t4_evv_after", 64'(ev_valid),    64'h0);
        check("t4_ovf_after", 64'(ev_overflow), 64'h1);

        // T5: clear blocked by active source, completes after it drops; clear in IDLE
        do_reset(3);
        ev_ready = 1;
        goto_edge(2);  err_in = 8'h10;
        goto_edge(15); clear_req = 1;
        goto_edge(16); clear_req = 0;
        goto_edge(30); at_neg();
        check("t5_hold_flags", 64'(err_flags), 64'h10);
        check("t5_hold_state", 64'(dbg_state), 64'(CLEARING));
        check("t5_hold_ack",   64'(clear_ack), 64'h0);
        goto_edge(39); err_in = 8'h00;
        goto_edge(42); at_neg();
        check("t5_ack_early",  64'(clear_ack), 64'h0);
        goto_edge(43); at_neg();
        check("t5_ack",        64'(clear_ack),   64'h1);
        check("t5_flags",      64'(err_flags),   64'h0);
        check("t5_fval",       64'(first_valid), 64'h0);
        goto_edge(45); clear_req = 1;
        goto_edge(46); clear_req = 0; at_neg();
        check("t5_idle_ack",   64'(clear_ack), 64'h1);
        goto_edge(47); at_neg();
        check("t5_idle_ack_end", 64'(clear_ack), 64'h0);

        // T6: reset while tripped with a pending event
        do_reset(3);
        goto_edge(2);  err_in = 8'h01;
        goto_edge(12); ARESET = 1; err_in = 8'h00;
        @(posedge ACLK); #1; at_neg();
        check("t6_flags", 64'(err_flags),   64'h0);
        check("t6_trip",  64'(trip),        64'h0);
        check("t6_evv",   64'(ev_valid),    64'h0);
        check("t6_fval",  64'(first_valid), 64'h0);
        ARESET = 0;
        goto_edge(4);  err_in = 8'h80;
        goto_edge(11); at_neg();
        check("t6_new_flags", 64'(err_flags), 64'h80);
        check("t6_new_fid",   64'(first_id),  64'd7);
        check("t6_new_fts",   64'(first_ts),  64'd11);

        // T7: filter_len = 0 accepts a single sample
        do_reset(0);
        goto_edge(4); err_in = 8'h08;
        goto_edge(5); err_in = 8'h00;
        goto_edge(7); at_neg();
        check("t7_flags_e7", 64'(err_flags), 64'h00);
        goto_edge(8); at_neg();
        check("t7_flags_e8", 64'(err_flags), 64'h08);

        // Randomized rounds against the model
        for (int r = 0; r < 6; r++) begin
            do_reset((r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 2 : (r == 3) ? 3 : (r == 4) ? 5 : 7);
            if (r % 2 == 1) err_mask = NUM_ERR'($urandom_range(0, 255));
            for (int c = 0; c < 1500; c++) begin
                @(posedge ACLK); #1;
                for (int b = 0; b < NUM_ERR; b++)
                    if ($urandom_range(0, 7) == 0) err_in[b] = ~err_in[b];
                ev_ready  = (r == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
                clear_req = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 199) == 0) err_mask = NUM_ERR'($urandom_range(0, 255));
            end
        end
        clear_req = 0;
        repeat (3) @(posedge ACLK);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
